// File: rtl/axis_uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// axis_uart_rx_pkg
// Shared definitions for the UART receiver and the apps that instantiate it.
//   CLOCK_FREQ / `BAUD_DIVISOR(baud) : one place to turn a baud rate into the
//                                      clocks-per-bit DIVISOR parameter.
//   rx_state_e                       : receiver state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef AXIS_UART_RX_DEFINES
`define AXIS_UART_RX_DEFINES
`define CLOCK_FREQ 133000000
// Rounded clocks-per-bit, e.g. `BAUD_DIVISOR(115200) == 1155 at 133 MHz.
`define BAUD_DIVISOR(baud) ((`CLOCK_FREQ + ((baud) / 2)) / (baud))
`endif

package axis_uart_rx_pkg;

   localparam int unsigned CLOCK_FREQ = `CLOCK_FREQ;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   // Same rounding as `BAUD_DIVISOR, usable in constant expressions.
   function automatic int unsigned baud_divisor(input int unsigned baud);
      return (CLOCK_FREQ + (baud / 2)) / baud;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Two-flop synchroniser for a single asynchronous pin (UART rx, buttons, ...).
//   clock       in  : destination clock
//   resetn      in  : asynchronous active-low reset
//   d           in  : asynchronous input
//   q           out : d synchronised to clock, two cycles of latency
// RESET_VALUE sets both stages during reset so an idle-high line does not
// look like an edge when reset releases.
// ---------------------------------------------------------------------------
module sync_bit #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta_q <= RESET_VALUE;
         sync_q <= RESET_VALUE;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/axis_uart_rx.sv
// ---------------------------------------------------------------------------
// axis_uart_rx
// 8N1-style UART receiver presenting received words as a valid/ready stream.
//   clock        in  : system clock
//   resetn       in  : asynchronous active-low reset
//   rx_pin       in  : raw serial line, idle high, asynchronous to clock
//   odata        out : received word (first bit on the wire lands in the LSB)
//   ovalid       out : odata holds an unconsumed word
//   oready       in  : word is consumed in a cycle where ovalid && oready
//   overrun      out : 1-cycle pulse, a finished frame was dropped (output full)
//   frame_error  out : 1-cycle pulse, stop bit sampled low
//
// Handshake: a word transfers on the rising edge that ends a cycle with
// ovalid && oready both high; odata is held stable while ovalid is high, and
// oready has no effect while ovalid is low or on the receive timing.
//
// The FSM samples the synchronised line at the middle of each bit: half a bit
// after the start edge, then once per DIVISOR cycles. A completed word is
// handed to the output register in the cycle after the stop sample.
// ---------------------------------------------------------------------------
module axis_uart_rx
   import axis_uart_rx_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 1155
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             rx_pin,
   output logic [WIDTH-1:0] odata,
   output logic             ovalid,
   input  logic             oready,
   output logic             overrun,
   output logic             frame_error
);

   localparam int CW = $clog2(DIVISOR);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] HALF_CNT = CW'(DIVISOR / 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIVISOR - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   logic rx_s;

   sync_bit #(
      .RESET_VALUE (1'b1)
   ) u_sync_rx (
      .clock  (clock),
      .resetn (resetn),
      .d      (rx_pin),
      .q      (rx_s)
   );

   rx_state_e        state_q,       state_d;
   logic [CW-1:0]    cnt_q,         cnt_d;
   logic [BW-1:0]    bit_q,         bit_d;
   logic [WIDTH-1:0] shift_q,       shift_d;
   logic             pend_q,        pend_d;
   logic [WIDTH-1:0] odata_q,       odata_d;
   logic             ovalid_q,      ovalid_d;
   logic             overrun_q,     overrun_d;
   logic             frame_error_q, frame_error_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_d         = bit_q;
      shift_d       = shift_q;
      pend_d        = 1'b0;
      odata_d       = odata_q;
      overrun_d     = 1'b0;
      frame_error_d = 1'b0;

      // A consumed word clears ovalid unless a new word is loaded below.
      ovalid_d = ovalid_q & ~oready;

      // Deliver stage: the shift register is untouched in IDLE and the first
      // half-bit of START, so it still holds the finished word here even if a
      // new start bit was already detected.
      if (pend_q) begin
         if (!ovalid_q || oready) begin
            odata_d  = shift_q;
            ovalid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end

         ST_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d = '0;
               bit_d = '0;
               // A line that is high again mid-start-bit was a glitch.
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[WIDTH-1:1]};
               if (bit_q == LAST_BIT) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (rx_s) begin
                  pend_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_BREAK: begin
            // A held-low line must return high before a new start is accepted.
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         pend_q        <= 1'b0;
         odata_q       <= '0;
         ovalid_q      <= 1'b0;
         overrun_q     <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         pend_q        <= pend_d;
         odata_q       <= odata_d;
         ovalid_q      <= ovalid_d;
         overrun_q     <= overrun_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign odata       = odata_q;
   assign ovalid      = ovalid_q;
   assign overrun     = overrun_q;
   assign frame_error = frame_error_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_axis_uart_rx
// Directed and randomised frames driven into axis_uart_rx (DIVISOR=8, H=4).
// A bit-level UART sender drives rx_pin; a negedge monitor collects accepted
// words and pulse counts; expected words live in exp_q.
// ---------------------------------------------------------------------------
module tb_axis_uart_rx;
   import axis_uart_rx_pkg::*;

   localparam int WIDTH   = 8;
   localparam int DIVISOR = 8;

   // ---------------- clock / reset ----------------
   logic             clock = 1'b0;
   logic             resetn;
   logic             rx_pin;
   logic [WIDTH-1:0] odata;
   logic             ovalid;
   logic             oready;
   logic             overrun;
   logic             frame_error;

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   axis_uart_rx #(
      .WIDTH   (WIDTH),
      .DIVISOR (DIVISOR)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .rx_pin      (rx_pin),
      .odata       (odata),
      .ovalid      (ovalid),
      .oready      (oready),
      .overrun     (overrun),
      .frame_error (frame_error)
   );

   // ---------------- scoreboard state ----------------
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] got_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int ovr_cnt = 0;
   int fe_cnt = 0;
   int ovalid_hi = 0;
   int stab_err = 0;
   int rise_cyc = -1;
   int start_cyc = 0;
   bit rand_ready = 1'b0;

   logic             ovalid_prev = 1'b0;
   logic             acc_prev = 1'b0;
   logic [WIDTH-1:0] odata_prev = '0;

   // Monitor: samples mid-cycle, away from the active edge.
   always @(negedge clock) begin
      if (ovalid === 1'b1) ovalid_hi++;
      if (ovalid === 1'b1 && ovalid_prev !== 1'b1) rise_cyc = cyc;
      if (ovalid_prev && !acc_prev && (ovalid !== 1'b1 || odata !== odata_prev)) stab_err++;
      if (ovalid === 1'b1 && oready === 1'b1) got_q.push_back(odata);
      if (overrun === 1'b1) ovr_cnt++;
      if (frame_error === 1'b1) fe_cnt++;
      ovalid_prev = (ovalid === 1'b1);
      acc_prev    = (ovalid === 1'b1) && (oready === 1'b1);
      odata_prev  = odata;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_ready) oready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      rx_pin = b;
      repeat (DIVISOR) tick();
   endtask

   // One frame: start bit, data LSB first, optional stretched-low stop, stop.
   task automatic send_frame(input logic [WIDTH-1:0] data, input int stop_low_bits);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < WIDTH; i++) send_bit(data[i]);
      if (stop_low_bits > 0) begin
         rx_pin = 1'b0;
         repeat (stop_low_bits * DIVISOR) tick();
      end
      send_bit(1'b1);
   endtask

   task automatic clear_stats();
      ovr_cnt   = 0;
      fe_cnt    = 0;
      ovalid_hi = 0;
      rise_cyc  = -1;
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- comparison ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_words(input string tag);
      int n;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] aborted;

      resetn = 1'b0;
      rx_pin = 1'b1;
      oready = 1'b0;
      idle(3);
      check("rst_odata",       32'(odata),       32'h0);
      check("rst_ovalid",      32'(ovalid),      32'h0);
      check("rst_overrun",     32'(overrun),     32'h0);
      check("rst_frame_error", 32'(frame_error), 32'h0);
      resetn = 1'b1;
      idle(5);

      // Single frame, latency and one-cycle valid
      clear_stats();
      oready = 1'b1;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 0);
      idle(10);
      check_words("single");
      check("single_valid_cycles", 32'(ovalid_hi), 32'd1);
      lat = rise_cyc - (start_cyc + 1);
      if (!(lat >= 78 && lat <= 80)) $display("latency observed %0d cycles, window 78..80", lat);
      check("single_latency_in_window", 32'(lat >= 78 && lat <= 80), 32'd1);
      check("single_overrun", 32'(ovr_cnt), 32'd0);
      check("single_ferr",    32'(fe_cnt),  32'd0);

      // Back-to-back frames
      clear_stats();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h3C);
      send_frame(8'h00, 0);
      send_frame(8'hFF, 0);
      send_frame(8'h3C, 0);
      idle(10);
      check_words("b2b");
      check("b2b_overrun", 32'(ovr_cnt), 32'd0);
      check("b2b_ferr",    32'(fe_cnt),  32'd0);

      // Overrun while downstream is stalled
      clear_stats();
      oready = 1'b0;
      send_frame(8'h11, 0);
      send_frame(8'h22, 0);
      idle(10);
      check("ovr_odata_held",  32'(odata),   32'h11);
      check("ovr_ovalid_held", 32'(ovalid),  32'h1);
      check("ovr_pulses",      32'(ovr_cnt), 32'd1);
      check("ovr_ferr",        32'(fe_cnt),  32'd0);
      oready = 1'b1;
      idle(2);
      check("ovr_ovalid_drop", 32'(ovalid), 32'h0);
      exp_q.push_back(8'h11);
      check_words("ovr");

      // Framing error with stop held low, then recovery
      clear_stats();
      send_frame(8'h55, 3);
      idle(10);
      check("ferr_pulses",   32'(fe_cnt),    32'd1);
      check("ferr_no_valid", 32'(ovalid_hi), 32'd0);
      check("ferr_overrun",  32'(ovr_cnt),   32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 0);
      idle(10);
      check_words("ferr_recover");
      check("ferr_recover_pulses", 32'(fe_cnt), 32'd1);

      // Short low glitch on an idle line
      clear_stats();
      rx_pin = 1'b0;
      idle(2);
      rx_pin = 1'b1;
      idle(20);
      check("glitch_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
      check("glitch_no_valid",   32'(ovalid_hi),   32'd0);
      check("glitch_ferr",       32'(fe_cnt),      32'd0);
      check("glitch_overrun",    32'(ovr_cnt),     32'd0);

      // Reset during data bit 4
      clear_stats();
      aborted = 8'hF0;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(aborted[i]);
      rx_pin = aborted[4];
      idle(4);
      resetn = 1'b0;
      rx_pin = 1'b1;
      idle(1);
      check("mid_rst_odata",       32'(odata),       32'h0);
      check("mid_rst_ovalid",      32'(ovalid),      32'h0);
      check("mid_rst_overrun",     32'(overrun),     32'h0);
      check("mid_rst_frame_error", 32'(frame_error), 32'h0);
      idle(9);
      resetn = 1'b1;
      idle(5);
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 0);
      idle(10);
      check_words("after_rst");
      check("after_rst_overrun", 32'(ovr_cnt), 32'd0);
      check("after_rst_ferr",    32'(fe_cnt),  32'd0);

      // Random data, random gaps, randomly toggling oready
      clear_stats();
      stab_err   = 0;
      rand_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         b = WIDTH'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_frame(b, 0);
         idle($urandom_range(0, 12));
      end
      idle(20);
      rand_ready = 1'b0;
      oready = 1'b1;
      idle(5);
      check_words("rand");
      check("rand_stable_while_valid", 32'(stab_err), 32'd0);
      check("rand_overrun", 32'(ovr_cnt), 32'd0);
      check("rand_ferr",    32'(fe_cnt),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case stimulus ever stalls.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule
